// File: rtl/uart_program_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_program_loader
//
// Receives 8N1 UART frames on RX while Load is high and writes each good byte
// into a program memory through a simple write port. Successive bytes go to
// successive addresses. The address wraps modulo Mem_depth. After Mem_depth
// writes, Full latches and further writes are suppressed. Reception continues
// while Full is set. A bad stop bit sets the sticky FE flag, and the byte is
// dropped.
//
// Parameters
//   Baudrate   clock cycles per UART bit (even, >= 4)
//   Mem_depth  program-memory size in bytes (power of two, <= 32)
//
// Ports
//   Clk      in   single clock, rising edge
//   Reset    in   asynchronous, active-high reset
//   RX       in   UART serial line (idle high, LSB first)
//   Load     in   level: 1 = loader enabled; a rising edge restarts at addr 0
//   Wr_en    out  one-cycle program-memory write strobe
//   Wr_addr  out  write address
//   Wr_data  out  last good received byte (valid with Wr_en)
//   FE       out  sticky frame-error flag
//   Full     out  Mem_depth bytes written since Load rose
//   Busy     out  frame reception in progress
// -----------------------------------------------------------------------------
module uart_program_loader #(
  parameter int Baudrate  = 24,
  parameter int Mem_depth = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RX,
  input  logic       Load,
  output logic       Wr_en,
  output logic [4:0] Wr_addr,
  output logic [7:0] Wr_data,
  output logic       FE,
  output logic       Full,
  output logic       Busy
);

  localparam int            TW        = $clog2(Baudrate);
  localparam logic [TW-1:0] T_HALF    = TW'(Baudrate / 2 - 1);
  localparam logic [TW-1:0] T_FULL    = TW'(Baudrate - 1);
  localparam logic [4:0]    ADDR_LAST = 5'(Mem_depth - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Synchronizer and edge-detect history
  logic rx_meta_q, rxs_q, rxs_prev_q;
  logic load_prev_q;

  // Receiver and write-port state
  logic [1:0]    state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic          wr_en_q,   wr_en_d;
  logic [4:0]    addr_q,    addr_d;
  logic [7:0]    data_q,    data_d;
  logic          fe_q,      fe_d;
  logic          full_q,    full_d;

  logic rx_fall;
  logic load_rise;
  logic stop_hit;

  // The synchronizer resets to the idle-line level. This avoids a false
  // start edge when reset is released.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      load_prev_q <= 1'b0;
    end else begin
      rx_meta_q   <= RX;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      load_prev_q <= Load;
    end
  end

  assign rx_fall   = rxs_prev_q & ~rxs_q;
  assign load_rise = Load & ~load_prev_q;
  // Stop-bit sample point. It is only honoured while the loader is enabled.
  assign stop_hit  = Load && (state_q == S_STOP) && (timer_q == T_FULL);

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    fe_d      = fe_q;
    full_d    = full_q;

    case (state_q)
      S_IDLE: begin
        if (Load && rx_fall) begin
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        // At mid start bit, confirm the line is still low. Otherwise treat
        // the edge as a glitch.
        if (timer_q == T_HALF) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          // LSB arrives first, so shift right and insert at the MSB.
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        // Return straight to IDLE. The next falling edge can be caught on
        // the following cycle, which allows back-to-back frames.
        if (timer_q == T_FULL) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping Load abandons any frame in flight.
    if (!Load) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      bit_idx_d = '0;
    end

    if (stop_hit) begin
      if (rxs_q) begin
        data_d  = shift_q;
        wr_en_d = ~full_q;
      end else begin
        fe_d = 1'b1;
      end
    end

    // The address advances the cycle after the strobe. The last slot sets
    // Full together with the wrap back to zero.
    if (wr_en_q && Load) begin
      addr_d = (addr_q + 5'd1) & ADDR_LAST;
      if (addr_q == ADDR_LAST) begin
        full_d = 1'b1;
      end
    end

    // A new load session starts from a clean slate.
    if (load_rise) begin
      addr_d = '0;
      fe_d   = 1'b0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= 8'h00;
      fe_q      <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      fe_q      <= fe_d;
      full_q    <= full_d;
    end
  end

  assign Wr_en   = wr_en_q;
  assign Wr_addr = addr_q;
  assign Wr_data = data_q;
  assign FE      = fe_q;
  assign Full    = full_q;
  assign Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_program_loader
//
// Directed bench for uart_program_loader (Baudrate = 24, 4 ns clock).
// Good frames push {address, byte} onto a scoreboard queue. A monitor pops
// an entry on every Wr_en and compares it.
// -----------------------------------------------------------------------------
module tb_uart_program_loader;

  localparam int BAUD = 24;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       RX;
  logic       Load;
  logic       Wr_en;
  logic [4:0] Wr_addr;
  logic [7:0] Wr_data;
  logic       FE;
  logic       Full;
  logic       Busy;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  uart_program_loader #(
    .Baudrate (BAUD),
    .Mem_depth(32)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .RX     (RX),
    .Load   (Load),
    .Wr_en  (Wr_en),
    .Wr_addr(Wr_addr),
    .Wr_data(Wr_data),
    .FE     (FE),
    .Full   (Full),
    .Busy   (Busy)
  );

  always #2 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: outputs are sampled on the falling edge.
  always @(negedge Clk) begin
    if (Wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en", 32'(Wr_en), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(Wr_addr), 32'(e.addr));
        check("wr_data", 32'(Wr_data), 32'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One 8N1 frame. This task is called and returns on a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    RX = 1'b0;
    idle(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      idle(BAUD);
    end
    RX = stop_bit;
    idle(BAUD);
    RX = 1'b1;
  endtask

  // Start bit plus the first nbits data bits. The line is left mid-frame.
  task automatic partial_frame(input logic [7:0] d, input int nbits);
    RX = 1'b0;
    idle(BAUD);
    for (int i = 0; i < nbits; i++) begin
      RX = d[i];
      idle(BAUD);
    end
  endtask

  task automatic good_frame(input logic [4:0] addr, input logic [7:0] d);
    exp_q.push_back('{addr: addr, data: d});
    send_frame(d, 1'b1);
  endtask

  task automatic toggle_load();
    Load = 1'b0;
    idle(2);
    Load = 1'b1;
    idle(2);
  endtask

  initial begin
    logic [7:0] seq [6];
    logic [7:0] d;
    seq[0] = 8'hC0; seq[1] = 8'h40; seq[2] = 8'hA3;
    seq[3] = 8'hE5; seq[4] = 8'hA0; seq[5] = 8'h00;

    // Reset state
    Reset = 1'b1;
    RX    = 1'b1;
    Load  = 1'b0;
    idle(3);
    check("rst_wr_en",   32'(Wr_en),   32'd0);
    check("rst_wr_addr", 32'(Wr_addr), 32'd0);
    check("rst_wr_data", 32'(Wr_data), 32'd0);
    check("rst_fe",      32'(FE),      32'd0);
    check("rst_full",    32'(Full),    32'd0);
    check("rst_busy",    32'(Busy),    32'd0);
    Reset = 1'b0;
    idle(3);
    Load = 1'b1;
    idle(3);

    // Six back-to-back frames
    for (int i = 0; i < 6; i++) good_frame(5'(i), seq[i]);
    idle(20);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_fe",      32'(FE),           32'd0);
    check("b2b_addr",    32'(Wr_addr),      32'd6);
    check("b2b_data",    32'(Wr_data),      32'h00);

    // Bad stop bit, then a good frame
    toggle_load();
    check("fe_addr0", 32'(Wr_addr), 32'd0);
    send_frame(8'hA3, 1'b0);
    idle(BAUD);
    check("fe_set",       32'(FE),      32'd1);
    check("fe_addr_hold", 32'(Wr_addr), 32'd0);
    good_frame(5'd0, 8'h55);
    idle(10);
    check("fe_sticky",  32'(FE),           32'd1);
    check("fe_next_addr", 32'(Wr_addr),    32'd1);
    check("fe_next_data", 32'(Wr_data),    32'h55);
    check("fe_drained", 32'(exp_q.size()), 32'd0);

    // Start-bit glitch while idle
    toggle_load();
    RX = 1'b0;
    idle(5);
    check("glitch_busy", 32'(Busy), 32'd1);
    idle(3);
    RX = 1'b1;
    idle(30);
    check("glitch_idle", 32'(Busy),    32'd0);
    check("glitch_fe",   32'(FE),      32'd0);
    check("glitch_addr", 32'(Wr_addr), 32'd0);

    // 33 frames: fill memory, then suppress the write
    for (int i = 0; i < 33; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 32) good_frame(5'(i), d);
      else        send_frame(d, 1'b1);
      if (i == 30) begin
        check("fill31_full", 32'(Full),    32'd0);
        check("fill31_addr", 32'(Wr_addr), 32'd31);
      end
      if (i == 31) begin
        check("fill32_full", 32'(Full),    32'd1);
        check("fill32_addr", 32'(Wr_addr), 32'd0);
      end
    end
    idle(10);
    check("full_held",    32'(Full),           32'd1);
    check("full_addr",    32'(Wr_addr),        32'd0);
    check("full_drained", 32'(exp_q.size()),   32'd0);

    // Load dropped mid-frame
    toggle_load();
    check("reload_full", 32'(Full), 32'd0);
    send_frame(8'h96, 1'b0);
    idle(BAUD);
    good_frame(5'd0, 8'h3C);
    idle(5);
    partial_frame(8'hC3, 4);
    idle(6);
    check("abort_busy_pre", 32'(Busy), 32'd1);
    Load = 1'b0;
    idle(1);
    check("abort_busy", 32'(Busy), 32'd0);
    RX = 1'b1;
    idle(BAUD * 8);
    check("abort_addr_hold", 32'(Wr_addr), 32'd1);
    check("abort_fe_hold",   32'(FE),      32'd1);
    check("abort_drained",   32'(exp_q.size()), 32'd0);
    Load = 1'b1;
    idle(1);
    check("relaunch_addr", 32'(Wr_addr), 32'd0);
    check("relaunch_fe",   32'(FE),      32'd0);
    check("relaunch_full", 32'(Full),    32'd0);

    // Reset pulsed mid-frame
    idle(5);
    good_frame(5'd0, 8'h5A);
    idle(5);
    partial_frame(8'h81, 3);
    Reset = 1'b1;
    RX    = 1'b1;
    #1;
    check("mrst_busy",    32'(Busy),    32'd0);
    check("mrst_wr_en",   32'(Wr_en),   32'd0);
    check("mrst_wr_addr", 32'(Wr_addr), 32'd0);
    check("mrst_wr_data", 32'(Wr_data), 32'd0);
    check("mrst_fe",      32'(FE),      32'd0);
    check("mrst_full",    32'(Full),    32'd0);
    @(negedge Clk);
    idle(2);
    Reset = 1'b0;
    idle(BAUD * 10);
    check("mrst_quiet_busy", 32'(Busy),    32'd0);
    check("mrst_quiet_addr", 32'(Wr_addr), 32'd0);
    good_frame(5'd0, 8'hB7);
    idle(10);
    check("mrst_next_addr", 32'(Wr_addr), 32'd1);
    check("mrst_next_data", 32'(Wr_data), 32'hB7);

    idle(20);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
